// File: rtl/pio_key_in.sv
// Avalon-MM input PIO: synchronised key/switch levels, per-bit edge capture, maskable level irq.
// Define PIO_KEY_IN_DEBOUNCE_EN to add a per-bit stable-time debouncer after the synchroniser.
module pio_key_in #(
    parameter int unsigned      WIDTH           = 4,
    parameter int unsigned      EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = '1,
    parameter int unsigned      DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] rise, fall, edge_det;
    logic             wr_en;

`ifdef PIO_KEY_IN_DEBOUNCE_EN
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [WIDTH-1:0]            stable_q, stable_d;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Counter only runs while the synchronised pin disagrees with the reported level.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable_d[i] = ~stable_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q <= RESET_LEVEL;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
`else
    logic unused_debounce_cfg;
    assign unused_debounce_cfg = ^DEBOUNCE_CYCLES;
    assign stable              = sync2_q;
`endif

    always_comb begin
        wr_en   = chipselect && !write_n;
        sync1_d = in_port;
        sync2_d = sync1_q;
        prev_d  = stable;
        rise    = stable & ~prev_q;
        fall    = ~stable & prev_q;
        case (EDGE_TYPE)
            0:       edge_det = rise;
            1:       edge_det = fall;
            default: edge_det = rise | fall;
        endcase

        irq_mask_d = irq_mask_q;
        if (wr_en && address == 2'd2) begin
            irq_mask_d = writedata;
        end

        // Clear first, then OR in new edges so a coincident edge wins over the clear.
        edge_capture_d = edge_capture_q;
        if (wr_en && address == 2'd3) begin
            edge_capture_d = edge_capture_q & ~writedata;
        end
        edge_capture_d = edge_capture_d | edge_det;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q        <= RESET_LEVEL;
            sync2_q        <= RESET_LEVEL;
            prev_q         <= RESET_LEVEL;
            edge_capture_q <= '0;
            irq_mask_q     <= '0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            prev_q         <= prev_d;
            edge_capture_q <= edge_capture_d;
            irq_mask_q     <= irq_mask_d;
        end
    end

    always_comb begin
        case (address)
            2'd0:    readdata = stable;
            2'd1:    readdata = '0;
            2'd2:    readdata = irq_mask_q;
            default: readdata = edge_capture_q;
        endcase
    end

    assign irq = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_pio_key_in.sv
// Directed self-checking bench for pio_key_in (WIDTH=4, falling-edge capture, idle-high keys).
// Runs the debounce sequence when PIO_KEY_IN_DEBOUNCE_EN is defined, the plain sequence otherwise.
module tb_pio_key_in;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] address;
    logic       chipselect;
    logic       write_n;
    logic [3:0] writedata;
    logic [3:0] readdata;
    logic [3:0] in_port;
    logic       irq;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    pio_key_in #(
        .WIDTH          (4),
        .EDGE_TYPE      (1),
        .RESET_LEVEL    (4'hF),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [1:0] a, input logic [3:0] exp, input string tag);
        address = a;
        #1;
        check(tag, {28'd0, readdata}, {28'd0, exp});
    endtask

    task automatic chk_irq(input logic exp, input string tag);
        check(tag, {31'd0, irq}, {31'd0, exp});
    endtask

    // One-cycle bus write; returns at posedge+1 of the edge that commits it.
    task automatic wr(input logic [1:0] a, input logic [3:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        reset      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 4'h0;
        in_port    = 4'hF;
        tick();
        tick();
        reset = 1'b0;
        tick();

        rd(2'd0, 4'hF, "reset_data");
        rd(2'd1, 4'h0, "reset_resv");
        rd(2'd2, 4'h0, "reset_mask");
        rd(2'd3, 4'h0, "reset_capture");
        chk_irq(1'b0, "reset_irq");

`ifndef PIO_KEY_IN_DEBOUNCE_EN
        wr(2'd2, 4'b0010);
        rd(2'd2, 4'b0010, "mask_write");

        // Bit 1 falls: two synchroniser edges to data, one more to capture.
        in_port = 4'hD;
        tick();
        rd(2'd0, 4'hF, "data_e1");
        tick();
        rd(2'd0, 4'hD, "data_e2");
        rd(2'd3, 4'h0, "capture_e2");
        chk_irq(1'b0, "irq_e2");
        tick();
        rd(2'd3, 4'b0010, "capture_e3");
        chk_irq(1'b1, "irq_e3");

        // Rising edge on bit 1 is ignored; then fall again and clear in the capturing cycle.
        in_port = 4'hF;
        tick();
        tick();
        tick();
        rd(2'd0, 4'hF, "data_rise");
        in_port = 4'hD;
        tick();
        tick();
        wr(2'd3, 4'b0010);
        rd(2'd3, 4'b0010, "set_wins");
        chk_irq(1'b1, "set_wins_irq");
        wr(2'd3, 4'b0010);
        rd(2'd3, 4'h0, "clear_w1c");
        chk_irq(1'b0, "clear_irq");

        // Mask off, falling edges on bits 0 and 3.
        wr(2'd2, 4'b0000);
        in_port = 4'h4;
        tick();
        tick();
        tick();
        rd(2'd0, 4'h4, "data_b03");
        rd(2'd3, 4'b1001, "capture_b03");
        chk_irq(1'b0, "irq_masked");
        wr(2'd2, 4'b1000);
        chk_irq(1'b1, "irq_unmask");

        // Reserved register and unselected writes are ignored.
        wr(2'd1, 4'hF);
        rd(2'd1, 4'h0, "resv_write");
        rd(2'd2, 4'b1000, "mask_kept");
        address    = 2'd3;
        writedata  = 4'hF;
        write_n    = 1'b0;
        tick();
        write_n    = 1'b1;
        rd(2'd3, 4'b1001, "no_cs_write");

        // Clear all, then rising edges must not capture.
        wr(2'd3, 4'hF);
        rd(2'd3, 4'h0, "clear_all");
        in_port = 4'hF;
        tick();
        tick();
        tick();
        rd(2'd0, 4'hF, "data_all_high");
        rd(2'd3, 4'h0, "no_rise_capture");

        // Mid-run reset returns to idle levels; no spurious edge on the first cycle after.
        wr(2'd2, 4'hF);
        in_port = 4'h0;
        tick();
        tick();
        rd(2'd0, 4'h0, "data_pre_reset");
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(2'd0, 4'hF, "post_reset_data");
        rd(2'd2, 4'h0, "post_reset_mask");
        rd(2'd3, 4'h0, "post_reset_capture");
        chk_irq(1'b0, "post_reset_irq");
        tick();
        rd(2'd0, 4'hF, "post_reset_e1");
        rd(2'd3, 4'h0, "post_reset_no_edge");
        tick();
        rd(2'd0, 4'h0, "post_reset_e2");
        tick();
        rd(2'd3, 4'hF, "post_reset_capture_all");
        chk_irq(1'b0, "post_reset_irq_masked");
`else
        wr(2'd2, 4'b0001);

        // 5-cycle glitch never reaches the 8-cycle stable requirement.
        in_port = 4'hE;
        for (int i = 0; i < 5; i++) tick();
        in_port = 4'hF;
        for (int i = 0; i < 15; i++) begin
            tick();
            rd(2'd0, 4'hF, "glitch_data");
        end
        rd(2'd3, 4'h0, "glitch_capture");
        chk_irq(1'b0, "glitch_irq");

        // Sustained low: level appears on the 10th edge, captured on the 11th.
        in_port = 4'hE;
        for (int i = 1; i <= 9; i++) begin
            tick();
            rd(2'd0, 4'hF, "hold_data_early");
        end
        tick();
        rd(2'd0, 4'hE, "hold_data_e10");
        rd(2'd3, 4'h0, "hold_capture_e10");
        tick();
        rd(2'd3, 4'b0001, "hold_capture_e11");
        chk_irq(1'b1, "hold_irq");
        for (int i = 0; i < 9; i++) tick();
        in_port = 4'hF;
        for (int i = 0; i < 12; i++) tick();
        rd(2'd0, 4'hF, "release_data");
        wr(2'd3, 4'hF);
        rd(2'd3, 4'h0, "db_clear");

        // Reset with counter at 4 and pin held low restarts the full latency.
        in_port = 4'hE;
        for (int i = 0; i < 6; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(2'd0, 4'hF, "db_reset_data");
        rd(2'd2, 4'h0, "db_reset_mask");
        rd(2'd3, 4'h0, "db_reset_capture");
        for (int i = 1; i <= 9; i++) begin
            tick();
            rd(2'd0, 4'hF, "db_reset_early");
        end
        tick();
        rd(2'd0, 4'hE, "db_reset_e10");
        tick();
        rd(2'd3, 4'b0001, "db_reset_capture_e11");
        chk_irq(1'b0, "db_reset_irq_masked");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
